// File: rtl/aes_seq_pkg.sv
// Shared types and known-answer constants for the AES self-test sequencer.
// The sequencer walks the enabled key sizes in ascending index order.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ENC,
        ST_DEC,
        ST_NEXT,
        ST_DONE
    } state_e;

    localparam logic [1:0] KS_128 = 2'd0;
    localparam logic [1:0] KS_192 = 2'd1;
    localparam logic [1:0] KS_256 = 2'd2;

    localparam logic [127:0] PT         = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] EXP_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] EXP_CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } ks_pick_t;

    function automatic logic [127:0] exp_ct(input logic [1:0] ks);
        case (ks)
            KS_192:  return EXP_CT_192;
            KS_256:  return EXP_CT_256;
            default: return EXP_CT_128;
        endcase
    endfunction

    // Lowest enabled key size whose index is at least 'from'.
    function automatic ks_pick_t first_enabled(input logic [2:0] mask, input int from);
        ks_pick_t pick;
        pick = '{valid: 1'b0, idx: KS_128};
        for (int i = 2; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                pick = '{valid: 1'b1, idx: 2'(i)};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/aes_phase_timer.sv
// Loadable down-counter that times the ENC and DEC phases; expired while zero.
module aes_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/aes_selftest_sequencer.sv
// Known-answer self-test sequencer for the 128/192/256-bit AES cipher/decipher pairs.
// All outputs are registered; their next values are derived from the next state.
module aes_selftest_sequencer
    import aes_seq_pkg::*;
#(
    parameter int LAT_128 = 12,
    parameter int LAT_192 = 14,
    parameter int LAT_256 = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   mode_mask,
    input  logic [127:0] cipher_data,
    input  logic [127:0] decipher_data,
    output logic [1:0]   core_sel,
    output logic         core_clr,
    output logic         dec_en,
    output logic         busy,
    output logic         done,
    output logic [2:0]   pass,
    output logic [2:0]   fail,
    output logic [7:0]   disp_byte
);

    localparam int LAT_MAX = (LAT_128 > LAT_192) ? ((LAT_128 > LAT_256) ? LAT_128 : LAT_256)
                                                 : ((LAT_192 > LAT_256) ? LAT_192 : LAT_256);
    localparam int TMR_W   = $clog2(LAT_MAX);

    function automatic logic [TMR_W-1:0] lat_m1(input logic [1:0] ks);
        case (ks)
            KS_192:  return TMR_W'(LAT_192 - 1);
            KS_256:  return TMR_W'(LAT_256 - 1);
            default: return TMR_W'(LAT_128 - 1);
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [2:0] mask_q, mask_d;
    logic [1:0] core_sel_q, core_sel_d;
    logic       ct_ok_q, ct_ok_d;
    logic [2:0] pass_q, pass_d;
    logic [2:0] fail_q, fail_d;
    logic [7:0] disp_q, disp_d;
    logic       core_clr_q, core_clr_d;
    logic       dec_en_q, dec_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic             timer_load;
    logic             timer_en;
    logic [TMR_W-1:0] timer_val;
    logic             timer_expired;

    logic     accept;
    logic     enc_exp;
    logic     dec_exp;
    logic     pt_ok;
    ks_pick_t first_pick;
    ks_pick_t next_pick;

    aes_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    assign accept     = (state_q == ST_IDLE || state_q == ST_DONE) && start && (mode_mask != 3'b000);
    assign enc_exp    = (state_q == ST_ENC) && timer_expired;
    assign dec_exp    = (state_q == ST_DEC) && timer_expired;
    assign pt_ok      = (decipher_data == PT);
    assign first_pick = first_enabled(mode_mask, 0);
    assign next_pick  = first_enabled(mask_q, int'(core_sel_q) + 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            core_sel_q <= KS_128;
            ct_ok_q    <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            disp_q     <= '0;
            core_clr_q <= 1'b0;
            dec_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            core_sel_q <= core_sel_d;
            ct_ok_q    <= ct_ok_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            disp_q     <= disp_d;
            core_clr_q <= core_clr_d;
            dec_en_q   <= dec_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal gets a default at the top of a comb block so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_val  = lat_m1(core_sel_q);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                timer_load = 1'b1;
                state_d    = ST_ENC;
            end
            ST_ENC: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    timer_load = 1'b1;
                    state_d    = ST_DEC;
                end
            end
            ST_DEC: begin
                timer_en = 1'b1;
                if (timer_expired) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                state_d = next_pick.valid ? ST_CLEAR : ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mask_d     = mask_q;
        core_sel_d = core_sel_q;
        ct_ok_d    = ct_ok_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        disp_d     = disp_q;
        if (accept) begin
            mask_d     = mode_mask;
            pass_d     = '0;
            fail_d     = '0;
            core_sel_d = first_pick.idx;
        end
        if (enc_exp) begin
            ct_ok_d = (cipher_data == exp_ct(core_sel_q));
            disp_d  = cipher_data[7:0];
        end
        if (dec_exp) begin
            disp_d             = decipher_data[7:0];
            pass_d[core_sel_q] = ct_ok_q & pt_ok;
            fail_d[core_sel_q] = ~(ct_ok_q & pt_ok);
        end
        if (state_q == ST_NEXT && next_pick.valid) begin
            core_sel_d = next_pick.idx;
        end
        core_clr_d = (state_d == ST_CLEAR);
        dec_en_d   = (state_d == ST_DEC);
        busy_d     = (state_d == ST_CLEAR) || (state_d == ST_ENC) ||
                     (state_d == ST_DEC)   || (state_d == ST_NEXT);
        done_d     = (state_d == ST_DONE);
    end

    assign core_sel  = core_sel_q;
    assign core_clr  = core_clr_q;
    assign dec_en    = dec_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign disp_byte = disp_q;

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
// Self-checking bench: a cycle-offset model of the self-test schedule plus pinned literal scenarios.
module tb_aes_selftest_sequencer;

    localparam logic [127:0] T_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   mode_mask = 3'b000;
    logic [127:0] cipher_data = '0;
    logic [127:0] decipher_data = '0;
    logic [1:0]   core_sel;
    logic         core_clr;
    logic         dec_en;
    logic         busy;
    logic         done;
    logic [2:0]   pass;
    logic [2:0]   fail;
    logic [7:0]   disp_byte;

    aes_selftest_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode_mask     (mode_mask),
        .cipher_data   (cipher_data),
        .decipher_data (decipher_data),
        .core_sel      (core_sel),
        .core_clr      (core_clr),
        .dec_en        (dec_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .disp_byte     (disp_byte)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: which key size is running, and the 1-based cycle offset inside that size's slot.
    bit       m_run;
    bit [2:0] m_mask;
    int       m_k;
    int       m_t;
    bit       m_ct_ok;
    bit [2:0] e_pass;
    bit [2:0] e_fail;
    bit [7:0] e_disp;
    bit       e_done;

    int       run_cyc;
    bit       rnd_corrupt;
    bit [2:0] flip_ct0;
    bit [2:0] zero_pt;
    bit       log_en;
    int       clr_cycles[$];
    int       sel_log[$];
    int       done_edge;
    bit       dec_seen;
    logic [7:0] disp_after_enc;

    function automatic logic [127:0] ref_ct(input int k);
        case (k)
            1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            2:       return 128'h8ea2b7ca516745bfeafc49904b496089;
            default: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        endcase
    endfunction

    function automatic int ref_lat(input int k);
        return 12 + 2 * k;
    endfunction

    function automatic int lowest_from(input bit [2:0] m, input int from);
        for (int i = from; i < 3; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_mask = 0; m_k = 0; m_t = 0; m_ct_ok = 0;
        e_pass = 0; e_fail = 0; e_disp = 0; e_done = 0;
    endtask

    task automatic check_reset_values();
        check("rst_core_sel", 32'(core_sel), 0);
        check("rst_core_clr", 32'(core_clr), 0);
        check("rst_dec_en", 32'(dec_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_disp", 32'(disp_byte), 0);
    endtask

    task automatic compare_outputs();
        int L;
        L = ref_lat(m_k);
        check("core_sel", 32'(core_sel), 32'(m_k));
        check("core_clr", 32'(core_clr), 32'(m_run && m_t == 1));
        check("dec_en", 32'(dec_en), 32'(m_run && m_t >= L + 2 && m_t <= 2 * L + 1));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(e_done));
        check("pass", 32'(pass), 32'(e_pass));
        check("fail", 32'(fail), 32'(e_fail));
        check("disp_byte", 32'(disp_byte), 32'(e_disp));
    endtask

    // Drive one cycle of inputs from negedge, advance the model for the coming edge, compare at next negedge.
    task automatic step(input logic st, input logic [2:0] mk);
        int L;
        int n;
        int b;
        logic [127:0] ct;
        logic [127:0] pt;
        ct = rand128();
        pt = rand128();
        L  = ref_lat(m_k);
        if (m_run && m_t == L + 1) begin
            ct = ref_ct(m_k);
            if (flip_ct0[m_k]) ct[0] = ~ct[0];
            else if (rnd_corrupt && $urandom_range(0, 3) == 0) begin
                b = $urandom_range(0, 127);
                ct[b] = ~ct[b];
            end
        end
        if (m_run && m_t == 2 * L + 1) begin
            pt = T_PT;
            if (zero_pt[m_k]) pt = '0;
            else if (rnd_corrupt && $urandom_range(0, 3) == 0) begin
                b = $urandom_range(0, 127);
                pt[b] = ~pt[b];
            end
        end
        start = st;
        mode_mask = mk;
        cipher_data = ct;
        decipher_data = pt;
        @(posedge clk);
        if (m_run) begin
            if (m_t == L + 1) begin
                m_ct_ok = (ct == ref_ct(m_k));
                e_disp  = ct[7:0];
            end
            if (m_t == 2 * L + 1) begin
                e_disp = pt[7:0];
                e_pass[m_k] = m_ct_ok && (pt == T_PT);
                e_fail[m_k] = !(m_ct_ok && (pt == T_PT));
            end
            if (m_t == 2 * L + 2) begin
                n = lowest_from(m_mask, m_k + 1);
                if (n < 0) begin
                    m_run = 0;
                    e_done = 1;
                end else begin
                    m_k = n;
                    m_t = 1;
                end
            end else begin
                m_t++;
            end
            run_cyc++;
        end else if (st && mk != 3'b000) begin
            m_run = 1; m_mask = mk; e_pass = 0; e_fail = 0;
            m_k = lowest_from(mk, 0); m_t = 1; e_done = 0;
            run_cyc = 0;
        end else begin
            run_cyc++;
        end
        @(negedge clk);
        compare_outputs();
        if (log_en && core_clr === 1'b1) begin
            clr_cycles.push_back(run_cyc + 1);
            sel_log.push_back(int'(core_sel));
        end
    endtask

    // Start a run and step until done or the budget runs out; poke_at injects a start while busy.
    task automatic directed(input logic [2:0] mk, input int poke_at);
        clr_cycles.delete();
        sel_log.delete();
        done_edge = -1;
        dec_seen = 0;
        disp_after_enc = '0;
        log_en = 1;
        step(1'b1, mk);
        for (int i = 0; i < 200 && done_edge < 0; i++) begin
            if (i == poke_at) begin
                step(1'b1, 3'b001);
                check("poke_busy", 32'(busy), 1);
                check("poke_core_sel", 32'(core_sel), 0);
            end else begin
                step(1'b0, mk);
            end
            if (dec_en === 1'b1 && !dec_seen) begin
                dec_seen = 1;
                disp_after_enc = disp_byte;
            end
            if (done === 1'b1) done_edge = run_cyc;
        end
        if (done_edge < 0) check("done_timeout", 32'(done), 1);
        log_en = 0;
    endtask

    initial begin
        model_reset();
        rnd_corrupt = 0; flip_ct0 = 0; zero_pt = 0; log_en = 0; run_cyc = 0;
        #12;
        @(negedge clk);
        check_reset_values();
        reset = 1'b1;

        // 128-bit only, all correct
        directed(3'b001, -1);
        check("d001_done_edge", 32'(done_edge), 26);
        check("d001_clr_count", 32'(clr_cycles.size()), 1);
        if (clr_cycles.size() > 0) check("d001_clr_cycle", 32'(clr_cycles[0]), 1);
        check("d001_pass", 32'(pass), 32'h1);
        check("d001_fail", 32'(fail), 0);
        check("d001_disp", 32'(disp_byte), 32'hff);

        // zero mask from DONE is ignored
        step(1'b1, 3'b000);
        check("zmask_done", 32'(done), 1);
        check("zmask_busy", 32'(busy), 0);

        // all sizes, with a start pulse injected during the 128-bit ENC phase
        directed(3'b111, 4);
        check("d111_done_edge", 32'(done_edge), 90);
        check("d111_clr_count", 32'(clr_cycles.size()), 3);
        if (clr_cycles.size() == 3) begin
            check("d111_clr0", 32'(clr_cycles[0]), 1);
            check("d111_clr1", 32'(clr_cycles[1]), 27);
            check("d111_clr2", 32'(clr_cycles[2]), 57);
            check("d111_sel0", 32'(sel_log[0]), 0);
            check("d111_sel1", 32'(sel_log[1]), 1);
            check("d111_sel2", 32'(sel_log[2]), 2);
        end
        check("d111_pass", 32'(pass), 32'h7);
        check("d111_fail", 32'(fail), 0);

        // 192-bit with a ciphertext bit error
        flip_ct0 = 3'b010;
        directed(3'b010, -1);
        flip_ct0 = 0;
        check("d010_done_edge", 32'(done_edge), 30);
        check("d010_pass", 32'(pass), 0);
        check("d010_fail", 32'(fail), 32'h2);
        check("d010_disp_enc", 32'(disp_after_enc), 32'h90);

        // 256-bit with an all-zero recovered plaintext
        zero_pt = 3'b100;
        directed(3'b100, -1);
        zero_pt = 0;
        check("d100_done_edge", 32'(done_edge), 34);
        check("d100_pass", 32'(pass), 0);
        check("d100_fail", 32'(fail), 32'h4);
        check("d100_disp", 32'(disp_byte), 0);

        // reset in the middle of ENC, then a clean run
        step(1'b1, 3'b111);
        repeat (5) step(1'b0, 3'b111);
        #2 reset = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step(1'b0, 3'b111);
        directed(3'b001, -1);
        check("post_rst_done_edge", 32'(done_edge), 26);
        check("post_rst_pass", 32'(pass), 32'h1);

        // randomized starts, masks and corruptions
        rnd_corrupt = 1;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
